// File: rtl/phase_receiver_pkg.sv
// -----------------------------------------------------------------------------
// phase_receiver_pkg
//   Shared definitions for the phase strobe bus endpoint: receiver states,
//   error codes, strobe width and the strobe classification record produced
//   by phase_receiver_onehot_check.
// -----------------------------------------------------------------------------
package phase_receiver_pkg;

    // Number of phases on the strobe bus and the width of a phase index.
    localparam int NPHASE = 5;
    localparam int PIDX_W = $clog2(NPHASE);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SYNCED = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE  = 2'b00;
    localparam err_code_t ERR_ORDER = 2'b01;
    localparam err_code_t ERR_MULTI = 2'b10;
    localparam err_code_t ERR_GAP   = 2'b11;

    // Classification of one phase_bus sample. Exactly one of zero/valid/multi
    // is set; idx is meaningful only when valid is set.
    typedef struct packed {
        logic              zero;
        logic              valid;
        logic              multi;
        logic [PIDX_W-1:0] idx;
    } strobe_class_t;

    // Phase that must follow idx in the 0 -> 1 -> ... -> NPHASE-1 -> 0 ring.
    function automatic logic [PIDX_W-1:0] next_phase(input logic [PIDX_W-1:0] idx);
        return (idx == PIDX_W'(NPHASE - 1)) ? '0 : idx + PIDX_W'(1);
    endfunction

endpackage

// File: rtl/phase_receiver_onehot_check.sv
// -----------------------------------------------------------------------------
// phase_receiver_onehot_check
//   Purely combinational classifier for a strobe bus sample: all-zero (gap),
//   valid one-hot (with bit index) or multi-hot. Usable by any strobe consumer.
//
//   Ports:
//     phase_bus_i  in   NPHASE  raw strobe sample
//     class_o      out  struct  zero / valid / multi flags plus one-hot index
// -----------------------------------------------------------------------------
module phase_receiver_onehot_check
    import phase_receiver_pkg::*;
(
    input  logic [NPHASE-1:0] phase_bus_i,
    output strobe_class_t     class_o
);

    logic [2:0]        ones;
    logic [PIDX_W-1:0] last_idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ones     = '0;
        last_idx = '0;
        for (int i = 0; i < NPHASE; i++) begin
            if (phase_bus_i[i]) begin
                ones     = ones + 3'd1;
                last_idx = PIDX_W'(i);
            end
        end
    end

    always_comb begin
        class_o.zero  = (ones == 3'd0);
        class_o.valid = (ones == 3'd1);
        class_o.multi = (ones >= 3'd2);
        class_o.idx   = last_idx;
    end

endmodule

// File: rtl/phase_receiver.sv
// -----------------------------------------------------------------------------
// phase_receiver
//   Datapath-side endpoint of the processor phase strobe bus. Follows the
//   one-hot phase sequence 0->1->2->3->4->0, emits a registered one-cycle
//   stage enable per accepted phase, counts retired instructions (accepted
//   phase 4 strobes), stops at an instruction boundary on halt request and
//   latches the first protocol fault until cleared.
//
//   Ports:
//     clock      in   1       system clock, rising edge
//     reset      in   1       synchronous, active-high
//     phase_bus  in   NPHASE  one-hot phase strobes, all-zero = gap
//     halt_req   in   1       stop after the next accepted phase 4
//     exec       in   1       leave HALTED, resync at next phase 0
//     clear_err  in   1       leave ERROR, resync at next phase 0
//     stage_en   out  NPHASE  one-cycle enable mirroring accepted strobe
//     cur_phase  out  PIDX_W  index of last accepted phase
//     synced     out  1       receiver is tracking the sequence
//     halted     out  1       receiver is halted at a boundary
//     err        out  1       receiver is in ERROR
//     err_code   out  2       first fault: 01 order, 10 multi-hot, 11 gap
//     retired    out  RET_W   retired instruction count, wraps silently
// -----------------------------------------------------------------------------
module phase_receiver
    import phase_receiver_pkg::*;
#(
    parameter int GAP_MAX = 3,
    parameter int RET_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NPHASE-1:0] phase_bus,
    input  logic              halt_req,
    input  logic              exec,
    input  logic              clear_err,
    output logic [NPHASE-1:0] stage_en,
    output logic [PIDX_W-1:0] cur_phase,
    output logic              synced,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [RET_W-1:0]  retired
);

    // Wide enough to hold GAP_MAX itself.
    localparam int GAP_W = $clog2(GAP_MAX + 2);

    strobe_class_t cls;

    state_e            state_q,    state_d;
    logic [NPHASE-1:0] stage_en_q, stage_en_d;
    logic [PIDX_W-1:0] cur_q,      cur_d;
    logic [PIDX_W-1:0] exp_q,      exp_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic [RET_W-1:0]  ret_q,      ret_d;
    err_code_t         code_q,     code_d;

    phase_receiver_onehot_check u_onehot_check (
        .phase_bus_i (phase_bus),
        .class_o     (cls)
    );

    // Next-state logic. Per-state escape inputs (exec, clear_err) are
    // evaluated before any strobe, and strobes never act outside SYNCED
    // except the phase-0 resync in UNSYNC.
    always_comb begin
        state_d    = state_q;
        stage_en_d = '0;
        cur_d      = cur_q;
        exp_d      = exp_q;
        gap_d      = gap_q;
        ret_d      = ret_q;
        code_d     = code_q;

        unique case (state_q)
            ST_UNSYNC: begin
                gap_d = '0;
                // Only a clean phase-0 strobe starts tracking; anything else,
                // multi-hot included, is ignored here.
                if (cls.valid && cls.idx == '0) begin
                    state_d    = ST_SYNCED;
                    stage_en_d = phase_bus;
                    cur_d      = '0;
                    exp_d      = next_phase('0);
                end
            end

            ST_SYNCED: begin
                if (cls.multi) begin
                    // Checked first so a multi-hot strobe that also breaks
                    // the order is reported as multi-hot.
                    state_d = ST_ERROR;
                    code_d  = ERR_MULTI;
                end else if (cls.zero) begin
                    if (gap_q == GAP_W'(GAP_MAX)) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_GAP;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else if (cls.idx != exp_q) begin
                    state_d = ST_ERROR;
                    code_d  = ERR_ORDER;
                end else begin
                    stage_en_d = phase_bus;
                    cur_d      = cls.idx;
                    exp_d      = next_phase(cls.idx);
                    gap_d      = '0;
                    if (cls.idx == PIDX_W'(NPHASE - 1)) begin
                        ret_d = ret_q + RET_W'(1);
                        // Halt only at the instruction boundary; the phase-4
                        // enable still goes out on the way into HALTED.
                        if (halt_req) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
            end

            ST_HALTED: begin
                if (exec) begin
                    state_d = ST_UNSYNC;
                end
            end

            ST_ERROR: begin
                if (clear_err) begin
                    state_d = ST_UNSYNC;
                    code_d  = ERR_NONE;
                end
            end

            default: begin
                state_d = ST_UNSYNC;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_UNSYNC;
            stage_en_q <= '0;
            cur_q      <= PIDX_W'(NPHASE - 1);
            exp_q      <= '0;
            gap_q      <= '0;
            ret_q      <= '0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            stage_en_q <= stage_en_d;
            cur_q      <= cur_d;
            exp_q      <= exp_d;
            gap_q      <= gap_d;
            ret_q      <= ret_d;
            code_q     <= code_d;
        end
    end

    // Status flags are decodes of the state register only, so no input has a
    // combinational path to any output.
    assign stage_en  = stage_en_q;
    assign cur_phase = cur_q;
    assign synced    = (state_q == ST_SYNCED);
    assign halted    = (state_q == ST_HALTED);
    assign err       = (state_q == ST_ERROR);
    assign err_code  = code_q;
    assign retired   = ret_q;

endmodule
